// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and default widths.
package instr_fetch_pkg;
  localparam int          ADDR_W_DEF    = 27;
  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_cache_line.sv
// Single-entry instruction cache line: tag/data/valid store with combinational hit compare.
module fetch_cache_line
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [ADDR_W-1:0] lookup,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;

  // Invalidation wins over a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_data;
    end
  end

  assign hit  = valid_q && !flush && (tag_q == lookup);
  assign data = data_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one bus read per request with timeout, abort/drain and optional
// single-entry cache enabled by INSTR_FETCH_CACHE_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_start,
  input  logic              abort,
  input  logic              flush,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_start,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_q,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic              busy
);
  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;

`ifdef INSTR_FETCH_CACHE_EN
  logic              hit;
  logic              fill;
  logic [DATA_W-1:0] cache_data;

  fetch_cache_line #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cache (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .lookup    (pc_in),
    .fill      (fill),
    .fill_tag  (addr_q),
    .fill_data (rdata_q),
    .hit       (hit),
    .data      (cache_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    instr_d     = instr_q;
    err_d       = err_q;
    pend_d      = pend_q;
    bus_start   = 1'b0;
    instr_valid = 1'b0;
    fetch_err   = 1'b0;
`ifdef INSTR_FETCH_CACHE_EN
    fill        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_start) begin
          addr_d = pc_in;
          err_d  = 1'b0;
          pend_d = 1'b0;
`ifdef INSTR_FETCH_CACHE_EN
          if (hit) begin
            rdata_d = cache_data;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          bus_start = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT;
          // An early completion is remembered and retired from WAIT.
          if (bus_done) begin
            pend_d  = 1'b1;
            rdata_d = bus_q;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = DRAIN;
        end else if (pend_q) begin
          state_d = DONE;
        end else if (bus_done) begin
          rdata_d = bus_q;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = NOP_INSTR;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          instr_valid = 1'b1;
          fetch_err   = err_q;
          instr_d     = rdata_q;
`ifdef INSTR_FETCH_CACHE_EN
          fill        = !err_q;
`endif
        end
      end
      DRAIN: begin
        // The counter keeps running from WAIT so the total wait is bounded by TIMEOUT.
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_done || (cnt_q >= CNT_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_addr = addr_q;
  assign instr    = instr_valid ? rdata_q : instr_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level reference model plus scoreboard monitor.
module tb_instr_fetch;
  localparam int          AW  = 27;
  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [DW-1:0] NOP = 32'h0;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          fetch_start;
  logic          abort;
  logic          flush;
  logic [AW-1:0] bus_addr;
  logic          bus_start;
  logic          bus_done;
  logic [DW-1:0] bus_q;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          fetch_err;
  logic          busy;

  instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .fetch_start (fetch_start),
    .abort       (abort),
    .flush       (flush),
    .bus_addr    (bus_addr),
    .bus_start   (bus_start),
    .bus_done    (bus_done),
    .bus_q       (bus_q),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] model_instr = NOP;
  bit            mon_en = 1'b0;

`ifdef INSTR_FETCH_CACHE_EN
  bit            c_valid = 1'b0;
  logic [AW-1:0] c_tag   = '0;
  logic [DW-1:0] c_data  = '0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int done_offset(input int d);
    if (d < 0) return TO + 1;
    else if (d == 0) return 2;
    else return d + 1;
  endfunction

  // Scoreboard monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus_start) begin
        if (addr_q.size() == 0) check("unexpected_bus_start", 64'(bus_start), 64'(0));
        else check("bus_addr", 64'(bus_addr), 64'(addr_q.pop_front()));
      end
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr_valid", 64'(instr_valid), 64'(0));
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("instr", 64'(instr), 64'(e[DW-1:0]));
          check("fetch_err", 64'(fetch_err), 64'(e[DW]));
          model_instr = e[DW-1:0];
        end
      end else begin
        check("instr_hold", 64'(instr), 64'(model_instr));
        check("err_without_valid", 64'(fetch_err), 64'(0));
      end
    end
  end

  // d: cycles after the bus_start cycle that bus_done arrives (<0 or >TO: never).
  // a: cycle offset (0 = bus_start cycle) of an abort pulse, <0 for none.
  task automatic run_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int d_in, input int a_in, input bit fl);
    bit hit, valid_exp, err_exp;
    int d, a, done_off, idle_off, limit, end_off;
    logic [DW-1:0] word, cdata;
    d = (d_in > TO) ? -1 : d_in;
    a = a_in;
    hit = 1'b0;
    cdata = '0;
`ifdef INSTR_FETCH_CACHE_EN
    if (fl) c_valid = 1'b0;
    hit = c_valid && (c_tag == addr);
    cdata = c_data;
`endif
    if (hit) begin
      d = -1;
      a = -1;
      done_off = 0;
    end else begin
      done_off = done_offset(d);
    end
    if (a > done_off) a = done_off;
    if (a == 0) d = -1;
    valid_exp = !(a >= 0 && a <= done_off);
    err_exp   = !hit && (d < 0);
    word      = hit ? cdata : (err_exp ? NOP : data);
    if (!hit && a != 0) addr_q.push_back(addr);
    if (valid_exp) begin
      exp_q.push_back({err_exp, word});
`ifdef INSTR_FETCH_CACHE_EN
      if (!err_exp) begin
        c_valid = 1'b1;
        c_tag   = addr;
        c_data  = word;
      end
`endif
    end
    if (hit || a == 0) idle_off = 1;
    else if (a >= 1 && a < done_off) idle_off = (d > a) ? d + 1 : TO + 1;
    else idle_off = done_off + 1;
    limit   = (a >= 0) ? a : done_off;
    end_off = (d > limit) ? d : limit;

    pc_in = addr; fetch_start = 1'b1; flush = fl; abort = 1'b0; bus_done = 1'b0;
    tick();
    flush = 1'b0;
    for (int off = 0; off <= end_off; off++) begin
      pc_in       = AW'($urandom);
      bus_done    = (off == d);
      bus_q       = (off == d) ? data : DW'($urandom);
      abort       = (off == a);
      fetch_start = (off <= limit) && ($urandom_range(0, 3) == 0);
      #1;
      check("busy", 64'(busy), 64'(off < idle_off));
      check("bus_start_timing", 64'(bus_start), 64'(off == 0 && !hit && a != 0));
      check("instr_valid_timing", 64'(instr_valid), 64'(valid_exp && off == done_off));
      tick();
    end
    fetch_start = 1'b0; abort = 1'b0; bus_done = 1'b0;
    #1;
    for (int off = end_off + 1; off <= idle_off; off++) begin
      check("busy_tail", 64'(busy), 64'(off < idle_off));
      if (off < idle_off) tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_in = '0; fetch_start = 1'b0; abort = 1'b0; flush = 1'b0;
    bus_done = 1'b0; bus_q = '0;
    repeat (3) tick();
    check("rst_bus_addr", 64'(bus_addr), 64'(0));
    check("rst_bus_start", 64'(bus_start), 64'(0));
    check("rst_instr", 64'(instr), 64'(NOP));
    check("rst_instr_valid", 64'(instr_valid), 64'(0));
    check("rst_fetch_err", 64'(fetch_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Directed scenarios from the test plan.
    run_fetch(27'h10, 32'hDEADBEEF, 4, -1, 1'b0);
    run_fetch(27'h44, 32'h11111111, -1, -1, 1'b0);
    run_fetch(27'h48, 32'h12345678, 7, 2, 1'b0);
    run_fetch(27'h4C, 32'h55AA55AA, 3, 3, 1'b0);
    run_fetch(27'h50, 32'h0F0F0F0F, 0, -1, 1'b0);
    run_fetch(27'h54, 32'hA5A5A5A5, 2, 3, 1'b0);
    run_fetch(27'h58, 32'h77777777, -1, 0, 1'b0);

    // Reset in the middle of WAIT, then a late bus_done.
    pc_in = 27'h60; fetch_start = 1'b1;
    addr_q.push_back(27'h60);
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_instr = NOP;
`ifdef INSTR_FETCH_CACHE_EN
    c_valid = 1'b0;
`endif
    check("midrst_bus_addr", 64'(bus_addr), 64'(0));
    check("midrst_instr", 64'(instr), 64'(NOP));
    check("midrst_busy", 64'(busy), 64'(0));
    bus_done = 1'b1; bus_q = 32'hBAD0BAD0;
    tick();
    bus_done = 1'b0;
    repeat (3) tick();
    check("late_done_busy", 64'(busy), 64'(0));

`ifdef INSTR_FETCH_CACHE_EN
    run_fetch(27'h20, 32'hCAFEF00D, 2, -1, 1'b0);
    run_fetch(27'h20, 32'h00000000, 3, -1, 1'b0);
    run_fetch(27'h20, 32'h0BADF00D, 1, -1, 1'b1);
`endif

    // Randomized transactions over a small address pool to exercise repeats.
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] ra;
      int d, a;
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3) << 4) : AW'($urandom);
      d  = $urandom_range(0, TO + 2);
      a  = ($urandom_range(0, 9) < 3) ? $urandom_range(0, done_offset(d > TO ? -1 : d)) : -1;
      run_fetch(ra, DW'($urandom), d, a, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("addr_q_empty", 64'(addr_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Downstream of the program counter: takes its address output and fetches one instruction word per request over the shared memory bus.
- Presents the word and a valid pulse to the decode/control stage.
- Owns bus request sequencing, timeout detection and abort/drain on pipeline flush.
- Sits between the program counter and the decode/control stage.

Parameters:
- ADDR_W, 27, address width; matches program counter width.
- DATA_W, 32, instruction word width.
- TIMEOUT, 255, max cycles waited for bus_done before declaring a fetch error; counter width is clog2(TIMEOUT+1).
- NOP_INSTR, 32'h0, word returned on timeout.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- pc_in  in  ADDR_W  fetch address from program counter.
- fetch_start  in  1  request a fetch of pc_in; accepted only in IDLE.
- abort  in  1  cancel current fetch (jump/interrupt flush).
- flush  in  1  invalidate cache (optional feature); ignored otherwise.
- bus_addr  out  ADDR_W  address to memory bus.
- bus_start  out  1  one-cycle bus request strobe.
- bus_done  in  1  one-cycle strobe, bus_q valid.
- bus_q  in  DATA_W  read data.
- instr  out  DATA_W  fetched instruction, held until next valid.
- instr_valid  out  1  one-cycle pulse, instr updated.
- fetch_err  out  1  one-cycle pulse coincident with instr_valid on timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset:
  - State is IDLE.
  - bus_addr=0, bus_start=0, instr=NOP_INSTR, instr_valid=0, fetch_err=0, busy=0, timeout counter=0.
  - Reset mid-fetch discards everything; a late bus_done after reset is ignored.
- IDLE:
  - fetch_start=1 (cycle 0): latch pc_in into bus_addr, go to REQ.
  - fetch_start while not IDLE is ignored. No queuing.
- REQ:
  - bus_start=1 for exactly this cycle (cycle 1). Clear counter, go to WAIT.
  - bus_done arriving in REQ is legal; treat as WAIT completion next cycle.
- WAIT:
  - Counter increments each cycle.
  - bus_done=1: latch bus_q into instr, go to DONE.
  - Counter reaches TIMEOUT without bus_done: instr=NOP_INSTR, set error flag, go to DONE.
- DONE:
  - instr_valid=1 for one cycle; fetch_err=1 if error flag set.
  - Return to IDLE. Minimum latency fetch_start to instr_valid is 3 cycles, with bus_done in cycle 1.
  - Back-to-back: fetch_start in DONE is ignored; accepted from the following IDLE cycle.
- abort:
  - In REQ: suppress bus_start, return to IDLE.
  - In WAIT: go to DRAIN.
  - In DONE: suppress instr_valid and fetch_err; instr is not updated.
  - In IDLE: no effect.
  - Priority: abort beats bus_done in the same cycle (go to DRAIN).
- DRAIN:
  - Wait for bus_done or timeout, discard data, return to IDLE. No instr_valid.
  - busy stays high so the bus is never re-requested with a transfer outstanding.
- bus_addr holds the latched address from REQ until next accepted fetch_start.
- pc_in changes after acceptance have no effect.

Optional Feature:
- Macro: INSTR_FETCH_CACHE_EN.
- When defined: single-entry cache (tag ADDR_W, data DATA_W, valid bit).
  - On fetch_start with valid && pc_in==tag: go directly to DONE with cached data. No bus_start; latency 1 cycle.
  - On a successful bus fetch, fill tag/data/valid. Timeouts and aborts never fill.
  - flush=1 clears valid the same cycle. A flush coinciding with a hit forces a miss.
  - Reset clears valid.
- When not defined: no cache logic; flush is an unused input; every fetch uses the bus.

Decomposition:
- Shared CPU package:
  - State enum (IDLE, REQ, WAIT, DONE, DRAIN).
  - ADDR_W/DATA_W defaults.
  - NOP_INSTR constant.
- One natural sub-module, fetch_cache_line: the single-entry tag/data/valid store with hit compare. Instantiated only under INSTR_FETCH_CACHE_EN.

Test Plan:
- Normal fetch: reset, pc_in=27'h000010, fetch_start, bus_done 4 cycles after bus_start with bus_q=32'hDEADBEEF -> one bus_start with bus_addr=27'h10; instr=32'hDEADBEEF, instr_valid single pulse, fetch_err=0, busy low afterwards.
- Timeout: TIMEOUT=8, never assert bus_done -> instr_valid and fetch_err pulse together 8 cycles into WAIT; instr=NOP_INSTR.
- Abort in WAIT: abort 2 cycles after bus_start, bus_done 5 cycles later with 32'h12345678 -> no instr_valid; instr unchanged; busy high until that bus_done; next fetch_start accepted after.
- Simultaneous abort+bus_done and fetch_start during busy -> no instr_valid; ignored start produces no second bus_start.
- Reset mid-WAIT, then late bus_done -> all outputs at reset values; late bus_done causes no instr_valid.
- INSTR_FETCH_CACHE_EN:
  - Fetch 27'h20 twice -> second fetch has no bus_start, instr_valid 1 cycle after fetch_start.
  - flush then refetch -> bus_start issued.
